dvi_video_timing: RTL
=====================

// Module: dvi_video_timing
// PURPOSE
//  Raster timing generator and pixel fetcher feeding the DVI output stage (TX_* inputs of the TMDS/serializer block).
//  Counts H/V position, generates HS/VS/DE, pulls pixels from an upstream first-word-fall-through FIFO, and substitutes
//  a border colour on underflow. All outputs are registered in the CLK (pixel clock) domain.
// PARAMETERS
//  H_ACT   640  active pixels/line          | H_FP 16 | H_SYNC 96 | H_BP 48   (pixels)
//  V_ACT   480  active lines/frame          | V_FP 10 | V_SYNC 2  | V_BP 33   (lines)
//  HS_POL  0    0=sync pulse active-low, 1=active-high (same for VS_POL)
//  VS_POL  0
//  BORDER  24'h000000  {R,G,B} sent on underflow
//  CW      12   counter width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  CLK          in   1   pixel clock
//  RESET        in   1   synchronous reset, active-high
//  EN           in   1   1=run raster; 0=hold counters at 0, blank outputs
//  PIX_DATA     in   24  {R[7:0],G[7:0],B[7:0]} head of upstream FWFT FIFO
//  PIX_EMPTY    in   1   FIFO empty
//  PIX_RD       out  1   FIFO pop strobe (combinational from counters + PIX_EMPTY)
//  TX_RED/GRN/BLU out 8 each  pixel to DVI stage
//  TX_HS, TX_VS out  1   syncs, polarity per HS_POL/VS_POL
//  TX_DE        out  1   data enable
//  FRAME_START  out  1   1-cycle pulse aligned with first TX_DE pixel of frame
//  UNDERFLOW    out  1   sticky; cleared at frame start
// BEHAVIOUR
//  - H_TOTAL=H_ACT+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt 0..H_TOTAL-1 wraps to 0 and increments v_cnt;
//    v_cnt 0..V_TOTAL-1 wraps to 0 when h_cnt wraps on line V_TOTAL-1. Counting occurs only while EN=1.
//  - Regions (h): active [0,H_ACT); FP; sync [H_ACT+H_FP, H_ACT+H_FP+H_SYNC); BP. Same scheme for v using v_cnt.
//  - de_w = h_active & v_active. hs_w = h_sync XOR !HS_POL. vs_w = v_sync XOR !VS_POL (line-granular, changes when h_cnt=0).
//  - PIX_RD = EN & de_w & !PIX_EMPTY. Pixel selected = PIX_EMPTY ? BORDER : PIX_DATA.
//  - Latency: counters at cycle N -> TX_* registered at N+1 (1 cycle). HS/VS/DE/RGB/FRAME_START share that single stage; no skew.
//  - Underflow: de_w & PIX_EMPTY -> BORDER output, no pop, UNDERFLOW<=1 at N+1. FRAME_START (h=0,v=0,EN) clears UNDERFLOW
//    at N+1 unless that same cycle underflows (set wins).
//  - Blanking (de_w=0): RGB outputs 0, no pop regardless of FIFO state.
//  - EN=0: counters forced to 0 next cycle; outputs next cycle: DE=0, RGB=0, HS/VS inactive level, FRAME_START=0, PIX_RD=0.
//    EN rising: raster restarts at (0,0) with FRAME_START on the first registered cycle. UNDERFLOW holds while EN=0.
//  - RESET (any time, incl. mid-line): counters=0, TX_DE=0, RGB=0, TX_HS=!HS_POL, TX_VS=!VS_POL, FRAME_START=0,
//    UNDERFLOW=0. PIX_RD=0 while RESET=1.
//  - No elaboration-time legality checks beyond CW width; every timing parameter must be >=1.
// STRUCTURE
//  - Shared include dvi_timing_defs.vh: `define sets for 640x480@60 and 800x600@60 timing, RGB width, BORDER default.
//  - Sub-module dvi_timing_counter (one axis: CW counter, inc/clear inputs, outputs cnt, wrap, active, sync);
//    instantiated twice (H with inc=EN, V with inc=EN&h_wrap). Top holds pixel mux, pop logic, output register.
// TESTING  (bench uses H 8/2/3/3 -> H_TOTAL 16, V 4/1/2/1 -> V_TOTAL 8, 128 cycles/frame, HS_POL=VS_POL=0)
//  1 FIFO never empty, ramp data 0x000001.. -> 32 pops/frame, TX_DE high 8 cyc/line for 4 lines, RGB = popped order, 1 cyc late.
//  2 Sync timing -> TX_HS low exactly 3 cyc starting 10 cyc after line start; TX_VS low for lines 5-6; period 16/128 cyc.
//  3 PIX_EMPTY forced high for pixels 3-4 of line 1 -> BORDER on those 2 pixels, no PIX_RD, UNDERFLOW=1 until next FRAME_START+1.
//  4 Deassert EN mid-line (h=5,v=2) for 10 cyc -> DE/RGB 0, syncs inactive; on re-enable FRAME_START pulse, raster from (0,0).
//  5 RESET 1 cyc at h=6,v=1 -> next cycle all outputs at reset values; raster restarts at (0,0), first DE 1 cyc after release.
//  6 HS_POL=1, VS_POL=1 rerun of 2 -> identical timing, inverted levels, reset levels low.

Source files
------------

// File: rtl/dvi_video_timing_pkg.sv
// Shared types and default timing for the DVI raster generator.
//   COLOR_W / PIX_W : per-channel and packed {R,G,B} pixel widths
//   rgb_t           : packed pixel payload
//   VGA_*           : 640x480@60 default raster timing
package dvi_video_timing_pkg;

    localparam int unsigned COLOR_W = 8;
    localparam int unsigned PIX_W   = 3 * COLOR_W;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    localparam logic [PIX_W-1:0] BORDER_DEFAULT = '0;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int unsigned VGA_H_ACT  = 640;
    localparam int unsigned VGA_H_FP   = 16;
    localparam int unsigned VGA_H_SYNC = 96;
    localparam int unsigned VGA_H_BP   = 48;
    localparam int unsigned VGA_V_ACT  = 480;
    localparam int unsigned VGA_V_FP   = 10;
    localparam int unsigned VGA_V_SYNC = 2;
    localparam int unsigned VGA_V_BP   = 33;

endpackage

// File: rtl/dvi_timing_counter.sv
// One raster axis: position counter plus region decode.
//   clk, rst : clock, synchronous active-high reset
//   inc      : advance one position (wraps after the last position)
//   clr      : force the count to 0 on the next edge (overrides inc)
//   cnt      : current position
//   wrap     : cnt is the last position of the axis
//   active   : cnt in [0, ACT)
//   sync     : cnt in [ACT+FP, ACT+FP+SYNC)
module dvi_timing_counter #(
    parameter int unsigned CW   = 12,
    parameter int unsigned ACT  = 640,
    parameter int unsigned FP   = 16,
    parameter int unsigned SYNC = 96,
    parameter int unsigned BP   = 48
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          active,
    output logic          sync
);

    localparam int unsigned  TOTAL      = ACT + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACT);
    localparam logic [CW-1:0] SYNC_START = CW'(ACT + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACT + FP + SYNC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next position: clear wins, then wrap-or-increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign wrap   = (cnt_q == LAST);
    assign active = (cnt_q < ACT_END);
    assign sync   = (cnt_q >= SYNC_START) && (cnt_q < SYNC_END);

endmodule

// File: rtl/dvi_video_timing.sv
// Raster timing generator and pixel fetcher for the DVI TX stage.
//   CLK, RESET        : pixel clock, synchronous active-high reset
//   EN                : run the raster; low holds counters at 0 and blanks outputs
//   PIX_DATA/EMPTY    : head word / empty flag of the upstream FWFT FIFO
//   PIX_RD            : FIFO pop, combinational from counters and PIX_EMPTY
//   TX_RED/GRN/BLU    : registered pixel, 0 in blanking, BORDER on underflow
//   TX_HS/TX_VS/TX_DE : registered syncs (polarity per HS_POL/VS_POL) and data enable
//   FRAME_START       : one-cycle pulse with the first active pixel of a frame
//   UNDERFLOW         : sticky underflow flag, cleared at frame start
module dvi_video_timing
    import dvi_video_timing_pkg::*;
#(
    parameter int unsigned       H_ACT  = VGA_H_ACT,
    parameter int unsigned       H_FP   = VGA_H_FP,
    parameter int unsigned       H_SYNC = VGA_H_SYNC,
    parameter int unsigned       H_BP   = VGA_H_BP,
    parameter int unsigned       V_ACT  = VGA_V_ACT,
    parameter int unsigned       V_FP   = VGA_V_FP,
    parameter int unsigned       V_SYNC = VGA_V_SYNC,
    parameter int unsigned       V_BP   = VGA_V_BP,
    parameter bit                HS_POL = 1'b0,
    parameter bit                VS_POL = 1'b0,
    parameter logic [PIX_W-1:0]  BORDER = BORDER_DEFAULT,
    parameter int unsigned       CW     = 12
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               EN,
    input  logic [PIX_W-1:0]   PIX_DATA,
    input  logic               PIX_EMPTY,
    output logic               PIX_RD,
    output logic [COLOR_W-1:0] TX_RED,
    output logic [COLOR_W-1:0] TX_GRN,
    output logic [COLOR_W-1:0] TX_BLU,
    output logic               TX_HS,
    output logic               TX_VS,
    output logic               TX_DE,
    output logic               FRAME_START,
    output logic               UNDERFLOW
);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap_unused;
    logic          h_active, v_active;
    logic          h_sync, v_sync;

    dvi_timing_counter #(
        .CW(CW), .ACT(H_ACT), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_cnt (
        .clk    (CLK),
        .rst    (RESET),
        .inc    (EN),
        .clr    (~EN),
        .cnt    (h_cnt),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    // Vertical axis steps once per completed line
    dvi_timing_counter #(
        .CW(CW), .ACT(V_ACT), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_cnt (
        .clk    (CLK),
        .rst    (RESET),
        .inc    (EN & h_wrap),
        .clr    (~EN),
        .cnt    (v_cnt),
        .wrap   (v_wrap_unused),
        .active (v_active),
        .sync   (v_sync)
    );

    logic de_w, hs_w, vs_w, frame_start_w, underflow_w;

    assign de_w          = h_active & v_active;
    assign hs_w          = h_sync ^ ~HS_POL;
    assign vs_w          = v_sync ^ ~VS_POL;
    assign frame_start_w = (h_cnt == '0) && (v_cnt == '0);
    assign underflow_w   = de_w & PIX_EMPTY;

    // Pop only while a real pixel is consumed; never during reset
    assign PIX_RD = EN & ~RESET & de_w & ~PIX_EMPTY;

    logic de_q, de_d;
    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic fs_q, fs_d;
    logic uf_q, uf_d;
    rgb_t rgb_q, rgb_d;

    // Single output stage; EN low forces blank/inactive but keeps the sticky flag
    always_comb begin
        de_d  = 1'b0;
        rgb_d = '0;
        hs_d  = ~HS_POL;
        vs_d  = ~VS_POL;
        fs_d  = 1'b0;
        uf_d  = uf_q;
        if (EN) begin
            de_d = de_w;
            hs_d = hs_w;
            vs_d = vs_w;
            fs_d = frame_start_w;
            if (de_w) begin
                rgb_d = PIX_EMPTY ? rgb_t'(BORDER) : rgb_t'(PIX_DATA);
            end
            // A set in the frame-start cycle wins over the clear
            if (underflow_w) begin
                uf_d = 1'b1;
            end else if (frame_start_w) begin
                uf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            de_q  <= 1'b0;
            rgb_q <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            fs_q  <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            de_q  <= de_d;
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
            uf_q  <= uf_d;
        end
    end

    assign TX_RED      = rgb_q.r;
    assign TX_GRN      = rgb_q.g;
    assign TX_BLU      = rgb_q.b;
    assign TX_HS       = hs_q;
    assign TX_VS       = vs_q;
    assign TX_DE       = de_q;
    assign FRAME_START = fs_q;
    assign UNDERFLOW   = uf_q;

endmodule
